// File: rtl/nn_inference_ctrl.sv
// Inference sequencer: gates each network run on frame_ready, sequences reset/settle/run,
// bounds the run with a watchdog and registers the classification result.
module nn_inference_ctrl #(
   parameter int NUM_OUTPUTS    = 10,
   parameter int DATA_WIDTH     = 16,
   parameter int RESET_CYCLES   = 1,
   parameter int SETTLE_CYCLES  = 1,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int COUNT_WIDTH    = 16,
   localparam int IDX_W         = $clog2(NUM_OUTPUTS)
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   mode_continuous_i,
   input  logic                   start_i,
   input  logic                   frame_ready_i,
   input  logic [DATA_WIDTH-1:0]  threshold_i,
   input  logic                   nn_max_valid_i,
   input  logic [IDX_W-1:0]       nn_max_index_i,
   input  logic [DATA_WIDTH-1:0]  nn_max_value_i,
   output logic                   nn_reset_o,
   output logic                   nn_valid_o,
   output logic                   busy_o,
   output logic [IDX_W-1:0]       result_index_o,
   output logic [DATA_WIDTH-1:0]  result_value_o,
   output logic                   result_valid_o,
   output logic                   result_confident_o,
   output logic                   timeout_err_o,
   output logic                   range_err_o,
   output logic [COUNT_WIDTH-1:0] infer_count_o,
   output logic [2:0]             dbg_state_o
);

   localparam int MAX_RS  = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
   localparam int MAX_CYC = (MAX_RS > TIMEOUT_CYCLES) ? MAX_RS : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W:0]   NUM_OUT_L   = (IDX_W + 1)'(NUM_OUTPUTS);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RESET_NN = 3'd1,
      S_SETTLE   = 3'd2,
      S_RUN      = 3'd3,
      S_DONE     = 3'd4
   } state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   start_pending_q, start_pending_d;
   logic [IDX_W-1:0]       result_index_q, result_index_d;
   logic [DATA_WIDTH-1:0]  result_value_q, result_value_d;
   logic                   result_confident_q, result_confident_d;
   logic                   timeout_err_q, timeout_err_d;
   logic                   range_err_q, range_err_d;
   logic [COUNT_WIDTH-1:0] infer_count_q, infer_count_d;
   logic                   launch;
   logic                   capture;
   logic                   in_range;

   assign launch   = frame_ready_i & (mode_continuous_i | start_i | start_pending_q);
   assign in_range = ({1'b0, nn_max_index_i} < NUM_OUT_L);

   // Network handshake: nn_valid_o is held high for the whole RUN phase; the network answers
   // with a single-cycle nn_max_valid_i, which is only accepted while nn_valid_o is high.
   always_comb begin
      state_d            = state_q;
      cnt_d              = cnt_q;
      start_pending_d    = start_pending_q | start_i;
      result_index_d     = result_index_q;
      result_value_d     = result_value_q;
      result_confident_d = result_confident_q;
      timeout_err_d      = timeout_err_q;
      range_err_d        = range_err_q;
      infer_count_d      = infer_count_q;
      capture            = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (launch) begin
               state_d         = S_RESET_NN;
               cnt_d           = '0;
               start_pending_d = 1'b0;
            end
         end
         S_RESET_NN: begin
            if (cnt_q == RST_LAST) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            // Completion takes priority over the terminal watchdog cycle.
            if (nn_max_valid_i) begin
               state_d = S_DONE;
               capture = 1'b1;
            end else if (cnt_q == TO_LAST) begin
               state_d       = S_IDLE;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (capture) begin
         result_index_d     = nn_max_index_i;
         result_value_d     = nn_max_value_i;
         result_confident_d = ($signed(nn_max_value_i) >= $signed(threshold_i)) & in_range;
         range_err_d        = range_err_q | ~in_range;
         if (infer_count_q != {COUNT_WIDTH{1'b1}}) begin
            infer_count_d = infer_count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q            <= S_IDLE;
         cnt_q              <= '0;
         start_pending_q    <= 1'b0;
         result_index_q     <= '0;
         result_value_q     <= '0;
         result_confident_q <= 1'b0;
         timeout_err_q      <= 1'b0;
         range_err_q        <= 1'b0;
         infer_count_q      <= '0;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         start_pending_q    <= start_pending_d;
         result_index_q     <= result_index_d;
         result_value_q     <= result_value_d;
         result_confident_q <= result_confident_d;
         timeout_err_q      <= timeout_err_d;
         range_err_q        <= range_err_d;
         infer_count_q      <= infer_count_d;
      end
   end

   assign nn_reset_o         = (state_q == S_RESET_NN);
   assign nn_valid_o         = (state_q == S_RUN);
   assign busy_o             = (state_q != S_IDLE);
   assign result_valid_o     = (state_q == S_DONE);
   assign result_index_o     = result_index_q;
   assign result_value_o     = result_value_q;
   assign result_confident_o = result_confident_q;
   assign timeout_err_o      = timeout_err_q;
   assign range_err_o        = range_err_q;
   assign infer_count_o      = infer_count_q;
   assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_nn_inference_ctrl.sv
// Bench for nn_inference_ctrl: a network responder answers each run from a job queue, a
// job-level model predicts each result into exp_q, and a monitor checks every result_valid.
module tb_nn_inference_ctrl;

   localparam int NO = 10;
   localparam int DW = 16;
   localparam int IW = 4;
   localparam int TO = 8;
   localparam int CW = 2;
   localparam int EW = IW + DW + 1 + CW;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          mode_continuous, start, frame_ready;
   logic [DW-1:0] threshold;
   logic          nn_max_valid;
   logic [IW-1:0] nn_max_index;
   logic [DW-1:0] nn_max_value;
   logic          nn_reset_o, nn_valid_o, busy_o, result_valid_o, result_confident_o;
   logic          timeout_err_o, range_err_o;
   logic [IW-1:0] result_index_o;
   logic [DW-1:0] result_value_o;
   logic [CW-1:0] infer_count_o;
   logic [2:0]    dbg_state_o;

   nn_inference_ctrl #(
      .NUM_OUTPUTS(NO), .DATA_WIDTH(DW), .RESET_CYCLES(1), .SETTLE_CYCLES(1),
      .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)
   ) dut (
      .clk_i(clk), .reset_i(reset), .mode_continuous_i(mode_continuous), .start_i(start),
      .frame_ready_i(frame_ready), .threshold_i(threshold), .nn_max_valid_i(nn_max_valid),
      .nn_max_index_i(nn_max_index), .nn_max_value_i(nn_max_value), .nn_reset_o(nn_reset_o),
      .nn_valid_o(nn_valid_o), .busy_o(busy_o), .result_index_o(result_index_o),
      .result_value_o(result_value_o), .result_valid_o(result_valid_o),
      .result_confident_o(result_confident_o), .timeout_err_o(timeout_err_o),
      .range_err_o(range_err_o), .infer_count_o(infer_count_o), .dbg_state_o(dbg_state_o)
   );

   // clock / reset block
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "bench time limit");
   end

   // scoreboard state and job-level reference model
   typedef struct {
      int            delay;
      logic [IW-1:0] idx;
      logic [DW-1:0] val;
   } job_t;

   job_t          job_q[$];
   logic [EW-1:0] exp_q[$];
   int            res_cyc_q[$];
   int            n_tests = 0;
   int            n_fail = 0;
   int            m_cnt = 0;
   logic [IW-1:0] m_idx = '0;
   logic [DW-1:0] m_val = '0;
   logic          m_conf = 1'b0;
   logic          m_to = 1'b0;
   logic          m_range = 1'b0;
   int            assert_cyc = -10;
   int            run_len = 0;
   int            last_run_len = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // A job answered on RUN cycle 1..TO completes; anything else runs into the watchdog.
   task automatic add_job(input int delay, input logic [IW-1:0] idx, input logic [DW-1:0] val);
      job_t j;
      j.delay = delay;
      j.idx   = idx;
      j.val   = val;
      job_q.push_back(j);
      if (delay >= 1 && delay <= TO) begin
         m_conf  = ($signed(val) >= $signed(threshold)) && (int'(idx) < NO);
         m_cnt   = (m_cnt == CMAX) ? m_cnt : m_cnt + 1;
         m_idx   = idx;
         m_val   = val;
         if (int'(idx) >= NO) m_range = 1'b1;
         exp_q.push_back({idx, val, m_conf, CW'(m_cnt)});
      end else begin
         m_to = 1'b1;
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_idx = '0; m_val = '0; m_conf = 1'b0; m_to = 1'b0; m_range = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // network responder: answers on the job's RUN cycle, drives noise outside RUN
   initial begin
      job_t cur;
      cur.delay = 0; cur.idx = '0; cur.val = '0;
      nn_max_valid = 1'b0; nn_max_index = '0; nn_max_value = '0;
      forever begin
         @(posedge clk);
         #1;
         if (nn_valid_o) begin
            run_len++;
            if (run_len == 1) begin
               if (job_q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL unexpected_run: run started at cycle %0d with no job queued", cyc);
                  cur.delay = 0;
               end else begin
                  cur = job_q.pop_front();
               end
            end
            if (run_len == cur.delay) begin
               nn_max_valid = 1'b1;
               nn_max_index = cur.idx;
               nn_max_value = cur.val;
               assert_cyc   = cyc;
            end else begin
               nn_max_valid = 1'b0;
               nn_max_index = IW'($urandom_range(0, 15));
               nn_max_value = DW'($urandom);
            end
         end else begin
            if (run_len != 0) last_run_len = run_len;
            run_len      = 0;
            nn_max_valid = 1'($urandom_range(0, 1));
            nn_max_index = IW'($urandom_range(0, 15));
            nn_max_value = DW'($urandom);
         end
      end
   end

   // monitor: every result_valid pops one expected result
   always @(negedge clk) begin
      if (!reset && result_valid_o) begin
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_result: result_valid at cycle %0d, index %0h", cyc, result_index_o);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("res_index", 32'(result_index_o), 32'(e[EW-1 -: IW]));
            check("res_value", 32'(result_value_o), 32'(e[CW+1 +: DW]));
            check("res_confident", 32'(result_confident_o), 32'(e[CW]));
            check("res_count", 32'(infer_count_o), 32'(e[CW-1:0]));
            check("res_latency", cyc, assert_cyc + 1);
         end
         res_cyc_q.push_back(cyc);
      end
   end

   // driver / test sequence
   initial begin
      int w;
      logic [IW-1:0] idxs [5];
      reset = 1'b1; mode_continuous = 1'b0; start = 1'b0; frame_ready = 1'b0;
      threshold = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_nn_reset", 32'(nn_reset_o), 0);
      check("rst_nn_valid", 32'(nn_valid_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_result_valid", 32'(result_valid_o), 0);
      check("rst_result_index", 32'(result_index_o), 0);
      check("rst_result_value", 32'(result_value_o), 0);
      check("rst_confident", 32'(result_confident_o), 0);
      check("rst_timeout_err", 32'(timeout_err_o), 0);
      check("rst_range_err", 32'(range_err_o), 0);
      check("rst_infer_count", 32'(infer_count_o), 0);
      tick();
      reset = 1'b0;
      tick();

      // single shot, answer on the 8th RUN cycle (coincides with the watchdog limit)
      threshold = 16'h0100; frame_ready = 1'b1;
      add_job(8, 4'd7, 16'h0180);
      start = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         check("t1_nn_reset", 32'(nn_reset_o), 32'(c == 1));
         check("t1_nn_valid", 32'(nn_valid_o), 32'(c >= 3 && c <= 10));
         check("t1_busy", 32'(busy_o), 32'(c >= 1 && c <= 11));
         check("t1_result_valid", 32'(result_valid_o), 32'(c == 11));
         tick();
         start = 1'b0;
      end
      check("t1_no_timeout", 32'(timeout_err_o), 32'(m_to));
      check("t1_count", 32'(infer_count_o), 32'(m_cnt));

      // pending start while frame not ready, plus a second start during RUN
      frame_ready = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         check("t2_idle_wait", 32'(busy_o), 0);
         tick();
      end
      add_job(5, 4'd3, DW'($urandom));
      add_job(6, 4'd9, DW'($urandom));
      frame_ready = 1'b1;
      @(negedge clk);
      check("t2_launch_cycle_busy", 32'(busy_o), 0);
      tick();
      @(negedge clk);
      check("t2_nn_reset", 32'(nn_reset_o), 1);
      tick();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (40) tick();
      check("t2_jobs_used", job_q.size(), 0);
      check("t2_results_seen", exp_q.size(), 0);
      check("t2_idle", 32'(busy_o), 0);

      // watchdog timeout
      last_run_len = 0;
      add_job(0, '0, '0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      check("t3_run_len", last_run_len, TO);
      check("t3_timeout_err", 32'(timeout_err_o), 32'(m_to));
      check("t3_count", 32'(infer_count_o), 32'(m_cnt));
      check("t3_index_held", 32'(result_index_o), 32'(m_idx));
      check("t3_value_held", 32'(result_value_o), 32'(m_val));

      // continuous mode, 5 runs, range error on the 3rd, negative value vs zero threshold
      threshold = '0;
      tick();
      idxs[0] = 4'd1; idxs[1] = 4'd4; idxs[2] = 4'd12; idxs[3] = 4'd0; idxs[4] = 4'd9;
      for (int i = 0; i < 5; i++) begin
         add_job(5, idxs[i], (i == 1) ? 16'hFF00 : DW'($urandom_range(0, 16'h7FFF)));
      end
      res_cyc_q.delete();
      mode_continuous = 1'b1;
      w = 0;
      while (job_q.size() != 0 && w < 200) begin
         tick();
         w++;
      end
      check("t4_all_runs_started", job_q.size(), 0);
      mode_continuous = 1'b0;
      repeat (30) tick();
      check("t4_result_count", res_cyc_q.size(), 5);
      for (int i = 1; i < 5 && i < res_cyc_q.size(); i++) begin
         check("t4_spacing", res_cyc_q[i] - res_cyc_q[i-1], 9);
      end
      check("t4_range_err", 32'(range_err_o), 32'(m_range));
      check("t4_idle", 32'(busy_o), 0);

      // randomized single shots; threshold changes after capture must not disturb the flag
      for (int k = 0; k < 16; k++) begin
         threshold = DW'($urandom);
         tick();
         add_job($urandom_range(1, 10), IW'($urandom_range(0, 15)), DW'($urandom));
         start = 1'b1;
         tick();
         start = 1'b0;
         repeat (18) tick();
         threshold = ~threshold;
         tick();
         @(negedge clk);
         check("t5_confident_held", 32'(result_confident_o), 32'(m_conf));
         check("t5_count", 32'(infer_count_o), 32'(m_cnt));
         check("t5_range_err", 32'(range_err_o), 32'(m_range));
         check("t5_timeout_err", 32'(timeout_err_o), 32'(m_to));
      end

      // asynchronous reset in the middle of a run
      add_job(0, '0, '0);
      start = 1'b1;
      tick();
      start = 1'b0;
      w = 0;
      while (!nn_valid_o && w < 10) begin
         tick();
         w++;
      end
      check("t6_in_run", 32'(nn_valid_o), 1);
      tick();
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("t6_nn_valid", 32'(nn_valid_o), 0);
      check("t6_nn_reset", 32'(nn_reset_o), 0);
      check("t6_busy", 32'(busy_o), 0);
      check("t6_index", 32'(result_index_o), 32'(m_idx));
      check("t6_value", 32'(result_value_o), 32'(m_val));
      check("t6_confident", 32'(result_confident_o), 32'(m_conf));
      check("t6_timeout_err", 32'(timeout_err_o), 32'(m_to));
      check("t6_range_err", 32'(range_err_o), 32'(m_range));
      check("t6_count", 32'(infer_count_o), 32'(m_cnt));
      tick();
      reset = 1'b0;
      tick();
      threshold = 16'h0100;
      add_job(4, 4'd2, 16'h0200);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (15) tick();
      check("t6_recover_count", 32'(infer_count_o), 32'(m_cnt));
      check("final_exp_empty", exp_q.size(), 0);
      check("final_jobs_empty", job_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
